aes_round_sequencer: RTL and testbench

Control FSM for the AES-128 decryption core. It sits between the I/O handshake block and the shared AES datapath. After the I/O block raises `io_ready`, it loads the message and key registers into the datapath. It then runs the key expansion and the full inverse-cipher round schedule, one operation per cycle, and finally returns `aes_ready`. The block contains no data: it only sequences the datapath through operation selects, round-key indices and column selects.

---
 rtl/aes_round_sequencer_pkg.sv | 32 +++
 rtl/aes_round_sequencer_if.sv | 24 ++
 rtl/aes_round_sequencer.sv | 118 +++++++++++
 tb/tb_aes_round_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/aes_round_sequencer_pkg.sv
// Shared types for the AES-128 decryption core: datapath op encoding,
// round-key width, cipher round count and the sequencer state encoding.
package aes_pkg;

  localparam int NR   = 10;
  localparam int RK_W = 4;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_ISR  = 3'd2,
    OP_ISB  = 3'd3,
    OP_ARK  = 3'd4,
    OP_IMC  = 3'd5
  } aes_op_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_KEYEXP,
    S_ARK_INIT,
    S_R_ISR,
    S_R_ISB,
    S_R_ARK,
    S_R_IMC,
    S_F_ISR,
    S_F_ISB,
    S_F_ARK,
    S_DONE
  } aes_seq_state_t;

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Control bundle between the round sequencer (master) and the I/O block
// plus the shared AES datapath (slave side).
interface aes_seq_if;

  logic                        io_ready;
  logic                        aes_ready;
  logic                        busy;
  aes_pkg::aes_op_t            op;
  logic [aes_pkg::RK_W-1:0]    rk_sel;
  logic [1:0]                  col_sel;
  logic                        ke_en;
  logic [aes_pkg::RK_W-1:0]    ke_idx;

  modport master (
    input  io_ready,
    output aes_ready, busy, op, rk_sel, col_sel, ke_en, ke_idx
  );

  modport slave (
    output io_ready,
    input  aes_ready, busy, op, rk_sel, col_sel, ke_en, ke_idx
  );

endinterface

// File: rtl/aes_round_sequencer.sv
// Moore FSM that walks the AES datapath through load, key expansion and the
// inverse-cipher round schedule, one operation per cycle.
module aes_round_sequencer #(
  parameter int NR = aes_pkg::NR
) (
  input  logic      clk,
  input  logic      reset,
  aes_seq_if.master bus
);
  import aes_pkg::*;

  localparam logic [RK_W-1:0] LAST_RK = RK_W'(NR);

  aes_seq_state_t  state;
  aes_seq_state_t  state_next;
  logic [RK_W-1:0] rnd;
  logic [RK_W-1:0] step;
  logic            ke_last;
  logic            col_last;

  // Step counts keys 1..NR as 0..NR-1 in KEYEXP, and columns 0..3 in R_IMC.
  assign ke_last  = (step == LAST_RK - 1'b1);
  assign col_last = (step == RK_W'(3));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      rnd   <= '0;
      step  <= '0;
    end else begin
      state <= state_next;

      if (state_next != state) begin
        step <= '0;
      end else if (state == S_KEYEXP || state == S_R_IMC) begin
        step <= step + 1'b1;
      end

      if (state == S_KEYEXP && state_next == S_ARK_INIT) begin
        rnd <= LAST_RK - 1'b1;
      end else if (state == S_R_IMC && state_next == S_R_ISR) begin
        rnd <= rnd - 1'b1;
      end
    end
  end

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (bus.io_ready) state_next = S_LOAD;
      S_LOAD:     state_next = S_KEYEXP;
      S_KEYEXP:   if (ke_last) state_next = S_ARK_INIT;
      S_ARK_INIT: state_next = S_R_ISR;
      S_R_ISR:    state_next = S_R_ISB;
      S_R_ISB:    state_next = S_R_ARK;
      S_R_ARK:    state_next = S_R_IMC;
      S_R_IMC: begin
        if (col_last) begin
          state_next = (rnd == RK_W'(1)) ? S_F_ISR : S_R_ISR;
        end
      end
      S_F_ISR:    state_next = S_F_ISB;
      S_F_ISB:    state_next = S_F_ARK;
      S_F_ARK:    state_next = S_DONE;
      // A start level left high after completion must not launch a new run.
      S_DONE:     if (!bus.io_ready) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.aes_ready = 1'b0;
    bus.busy      = 1'b1;
    bus.op        = OP_NOP;
    bus.rk_sel    = '0;
    bus.col_sel   = '0;
    bus.ke_en     = 1'b0;
    bus.ke_idx    = '0;
    case (state)
      S_IDLE:     bus.busy = 1'b0;
      S_LOAD:     bus.op = OP_LOAD;
      S_KEYEXP: begin
        bus.ke_en  = 1'b1;
        bus.ke_idx = step + 1'b1;
      end
      S_ARK_INIT: begin
        bus.op     = OP_ARK;
        bus.rk_sel = LAST_RK;
      end
      S_R_ISR,
      S_F_ISR:    bus.op = OP_ISR;
      S_R_ISB,
      S_F_ISB:    bus.op = OP_ISB;
      S_R_ARK: begin
        bus.op     = OP_ARK;
        bus.rk_sel = rnd;
      end
      S_R_IMC: begin
        bus.op      = OP_IMC;
        bus.col_sel = step[1:0];
      end
      S_F_ARK: begin
        bus.op     = OP_ARK;
        bus.rk_sel = '0;
      end
      S_DONE: begin
        bus.busy      = 1'b0;
        bus.aes_ready = 1'b1;
      end
      default:    bus.busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench: a phase-level model pushes the golden op trace at each
// accepted start; a negedge monitor pops and compares whatever the DUT shows.
module tb_aes_round_sequencer;
  import aes_pkg::*;

  localparam int LAT = 8 * NR - 2;

  typedef struct packed {
    aes_op_t    op;
    logic [3:0] rk;
    logic [1:0] col;
    logic       ke_en;
    logic [3:0] ke_idx;
  } rec_t;

  typedef enum int {PH_IDLE, PH_RUN, PH_DONE} phase_t;

  logic clk = 1'b0;
  logic reset;

  aes_seq_if bus ();

  aes_round_sequencer #(.NR(NR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  rec_t   exp_q[$];
  int     done_q[$];
  phase_t m_phase     = PH_IDLE;
  int     m_rem       = 0;
  int     cyc         = 0;
  int     runs_model  = 0;
  int     runs_seen   = 0;
  int     n_checks    = 0;
  int     n_fail      = 0;
  logic   prev_ready  = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic rec_t mk(input aes_op_t op, input int rk, input int col,
                              input logic ke, input int ki);
    rec_t r;
    r.op     = op;
    r.rk     = 4'(rk);
    r.col    = 2'(col);
    r.ke_en  = ke;
    r.ke_idx = 4'(ki);
    return r;
  endfunction

  // Golden schedule straight from the cipher's structure.
  function automatic void push_run();
    exp_q.push_back(mk(OP_LOAD, 0, 0, 1'b0, 0));
    for (int k = 1; k <= NR; k++) exp_q.push_back(mk(OP_NOP, 0, 0, 1'b1, k));
    exp_q.push_back(mk(OP_ARK, NR, 0, 1'b0, 0));
    for (int r = NR - 1; r >= 1; r--) begin
      exp_q.push_back(mk(OP_ISR, 0, 0, 1'b0, 0));
      exp_q.push_back(mk(OP_ISB, 0, 0, 1'b0, 0));
      exp_q.push_back(mk(OP_ARK, r, 0, 1'b0, 0));
      for (int c = 0; c < 4; c++) exp_q.push_back(mk(OP_IMC, 0, c, 1'b0, 0));
    end
    exp_q.push_back(mk(OP_ISR, 0, 0, 1'b0, 0));
    exp_q.push_back(mk(OP_ISB, 0, 0, 1'b0, 0));
    exp_q.push_back(mk(OP_ARK, 0, 0, 1'b0, 0));
  endfunction

  // Reference model: idle / running (fixed length) / done-until-start-drops.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_phase = PH_IDLE;
      exp_q.delete();
      done_q.delete();
    end else begin
      case (m_phase)
        PH_IDLE: if (bus.io_ready) begin
          push_run();
          done_q.push_back(cyc + LAT);
          m_rem   = LAT;
          m_phase = PH_RUN;
        end
        PH_RUN: begin
          m_rem--;
          if (m_rem == 0) begin
            m_phase = PH_DONE;
            runs_model++;
          end
        end
        PH_DONE: if (!bus.io_ready) m_phase = PH_IDLE;
        default: m_phase = PH_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin : monitor
    rec_t got;
    got.op     = bus.op;
    got.rk     = bus.rk_sel;
    got.col    = bus.col_sel;
    got.ke_en  = bus.ke_en;
    got.ke_idx = bus.ke_idx;
    if (bus.busy === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_busy", 32'(bus.busy), 32'd0);
      else                   check("op_trace", 32'(got), 32'(exp_q.pop_front()));
    end else begin
      check("quiet_outputs", 32'(got), 32'd0);
    end
    check("busy", 32'(bus.busy), 32'(m_phase == PH_RUN));
    check("aes_ready", 32'(bus.aes_ready), 32'(m_phase == PH_DONE));
    if (bus.aes_ready === 1'b1 && prev_ready !== 1'b1) begin
      runs_seen++;
      if (done_q.size() == 0) check("unexpected_done", 32'(bus.aes_ready), 32'd0);
      else                    check("latency", 32'(cyc), 32'(done_q.pop_front()));
    end
    prev_ready = bus.aes_ready;
  end

  // Inputs change 2 time units after the edge so the next edge samples them cleanly.
  task automatic drive(input logic ir, input logic rs, input int n);
    bus.io_ready = ir;
    reset        = rs;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    int gap, hold;
    drive(1'b0, 1'b1, 3);
    drive(1'b0, 1'b0, 20);                 // reset then idle
    drive(1'b1, 1'b0, 90);                 // single run, start held
    drive(1'b0, 1'b0, 3);
    drive(1'b1, 1'b0, 200);                // held start: one run only
    drive(1'b0, 1'b0, 3);
    drive(1'b1, 1'b0, 31);                 // drop start mid-run
    drive(1'b0, 1'b0, 60);
    drive(1'b1, 1'b0, 40);                 // reset mid-run
    drive(1'b0, 1'b1, 1);
    drive(1'b0, 1'b0, 5);
    drive(1'b1, 1'b0, 85);                 // clean run after reset, then back-to-back
    drive(1'b0, 1'b0, 2);
    drive(1'b1, 1'b0, 85);
    drive(1'b0, 1'b0, 3);
    for (int it = 0; it < 8; it++) begin
      gap  = int'($urandom_range(0, 4));
      hold = int'($urandom_range(1, 100));
      drive(1'b0, 1'b0, gap + 1);
      drive(1'b1, 1'b0, hold);
      if ($urandom_range(0, 3) == 0) begin
        drive(1'b0, 1'b1, 1);
        drive(1'b0, 1'b0, 2);
      end else begin
        drive(1'b0, 1'b0, 90);
      end
    end
    drive(1'b0, 1'b0, 90);
    check("trace_drained", 32'(exp_q.size()), 32'd0);
    check("run_count", 32'(runs_seen), 32'(runs_model));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
